// File: rtl/entropy_codeword_gen.sv
// entropy_codeword_gen
// Turns an unsigned magnitude (optionally signed) into a Rice / exp-Golomb
// hybrid codeword. Small quotients use Rice coding. Larger ones escape to an
// exp-Golomb code whose value is offset past the Rice range. The codeword is
// produced by a 3-stage pipeline that carries a valid bit per stage and
// advances as a whole.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   in_valid/in_ready  input handshake; codebook inputs sampled on accept only
//   val                unsigned magnitude (VAL_W bits)
//   is_signed/is_minus append a sign bit for non-zero val; 1 = negative
//   k_rice, k_exp      Rice and exp-Golomb parameters
//   last_rice_q        largest quotient still coded as Rice
//   out_valid/out_ready output handshake
//   code, len          codeword (right-aligned, MSB first) and its bit length
//   too_long           len exceeds MAX_LEN (len saturates at 2^LEN_W-1)

module entropy_codeword_gen #(
    parameter int VAL_W   = 16,
    parameter int CODE_W  = 32,
    parameter int LEN_W   = 6,
    parameter int MAX_LEN = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VAL_W-1:0]  val,
    input  logic              is_signed,
    input  logic              is_minus,
    input  logic [2:0]        k_rice,
    input  logic [2:0]        k_exp,
    input  logic [2:0]        last_rice_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code,
    output logic [LEN_W-1:0]  len,
    output logic              too_long
);

    localparam int VW1 = VAL_W + 1;
    localparam int RAW_W = VAL_W + 2;
    localparam logic [31:0] LEN_SAT = 32'((1 << LEN_W) - 1);

    logic advance;

    // Stage 1 registers: raw symbol fields
    logic             s1_valid;
    logic [VAL_W-1:0] s1_val;
    logic             s1_signed;
    logic             s1_minus;
    logic [2:0]       s1_k_rice;
    logic [2:0]       s1_k_exp;
    logic [2:0]       s1_lrq;
    logic [VAL_W-1:0] s1_q;
    logic             s1_rice;

    // Stage 2 registers: fields plus quotient and mode decision
    logic             s2_valid;
    logic [VAL_W-1:0] s2_val;
    logic             s2_signed;
    logic             s2_minus;
    logic [2:0]       s2_k_rice;
    logic [2:0]       s2_k_exp;
    logic [2:0]       s2_lrq;
    logic [VAL_W-1:0] s2_q;
    logic             s2_rice;

    // Stage 2 combinational results
    logic [VW1-1:0]    base_off;
    logic [VW1-1:0]    kexp_off;
    logic [VW1-1:0]    v2;
    logic [31:0]       msb_idx;
    logic [VW1-1:0]    rice_bit;
    logic [VW1-1:0]    rice_code;
    logic [VW1-1:0]    raw_code;
    logic [31:0]       raw_len;
    logic              sign_on;
    logic [RAW_W-1:0]  full_code;
    logic [31:0]       full_len;
    logic [CODE_W-1:0] code_next;
    logic [LEN_W-1:0]  len_next;
    logic              too_long_next;

    // The whole pipeline moves together; a stalled output freezes every stage,
    // so bubbles are never squeezed out and nothing is duplicated.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_val    <= '0;
            s1_signed <= 1'b0;
            s1_minus  <= 1'b0;
            s1_k_rice <= '0;
            s1_k_exp  <= '0;
            s1_lrq    <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_val    <= val;
                s1_signed <= is_signed;
                s1_minus  <= is_minus;
                s1_k_rice <= k_rice;
                s1_k_exp  <= k_exp;
                s1_lrq    <= last_rice_q;
            end
        end
    end

    assign s1_q    = s1_val >> s1_k_rice;
    assign s1_rice = (s1_q <= VAL_W'(s1_lrq));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid  <= 1'b0;
            s2_val    <= '0;
            s2_signed <= 1'b0;
            s2_minus  <= 1'b0;
            s2_k_rice <= '0;
            s2_k_exp  <= '0;
            s2_lrq    <= '0;
            s2_q      <= '0;
            s2_rice   <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_val    <= s1_val;
                s2_signed <= s1_signed;
                s2_minus  <= s1_minus;
                s2_k_rice <= s1_k_rice;
                s2_k_exp  <= s1_k_exp;
                s2_lrq    <= s1_lrq;
                s2_q      <= s1_q;
                s2_rice   <= s1_rice;
            end
        end
    end

    // In exp mode q > last_rice_q, so val >= (last_rice_q+1)<<k_rice and v2 is
    // at least 1<<k_exp: the subtraction never underflows and e >= k_exp,
    // keeping the length expression non-negative.
    always_comb begin
        base_off = (VW1'(s2_lrq) + VW1'(1)) << s2_k_rice;
        kexp_off = VW1'(1) << s2_k_exp;
        v2       = {1'b0, s2_val} - base_off + kexp_off;

        msb_idx = 32'd0;
        for (int i = 0; i < VW1; i++) begin
            if (v2[i]) begin
                msb_idx = 32'(i);
            end
        end

        rice_bit  = VW1'(1) << s2_k_rice;
        rice_code = rice_bit | ({1'b0, s2_val} & (rice_bit - VW1'(1)));

        if (s2_rice) begin
            raw_code = rice_code;
            raw_len  = 32'(s2_q) + 32'(s2_k_rice) + 32'd1;
        end else begin
            raw_code = v2;
            raw_len  = (msb_idx << 1) + 32'(s2_lrq) + 32'd2 - 32'(s2_k_exp);
        end

        sign_on = s2_signed && (s2_val != '0);
        if (sign_on) begin
            full_code = {raw_code, s2_minus};
            full_len  = raw_len + 32'd1;
        end else begin
            full_code = {1'b0, raw_code};
            full_len  = raw_len;
        end

        code_next     = CODE_W'(full_code);
        too_long_next = (full_len > 32'(MAX_LEN));
        len_next      = (full_len > LEN_SAT) ? LEN_W'(LEN_SAT) : LEN_W'(full_len);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            code      <= '0;
            len       <= '0;
            too_long  <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                code     <= code_next;
                len      <= len_next;
                too_long <= too_long_next;
            end
        end
    end

endmodule

// File: tb/tb_entropy_codeword_gen.sv
// tb_entropy_codeword_gen
// Directed testbench for entropy_codeword_gen. The stimulus pushes
// hand-computed codewords into a queue when each symbol is accepted. A
// separate monitor pops and compares on every output handshake. The monitor
// also checks that the outputs hold steady while stalled.

module tb_entropy_codeword_gen;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] val;
    logic        is_signed;
    logic        is_minus;
    logic [2:0]  k_rice;
    logic [2:0]  k_exp;
    logic [2:0]  last_rice_q;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] code;
    logic [5:0]  len;
    logic        too_long;

    typedef struct {
        logic [31:0] code;
        logic [5:0]  len;
        logic        tl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic toggle_en = 1'b0;

    entropy_codeword_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .val         (val),
        .is_signed   (is_signed),
        .is_minus    (is_minus),
        .k_rice      (k_rice),
        .k_exp       (k_exp),
        .last_rice_q (last_rice_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .code        (code),
        .len         (len),
        .too_long    (too_long)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Present one symbol and hold it until accepted. Expectation is queued on
    // the accepting edge. Returns at posedge+1 with in_valid still high.
    task automatic applyStimulus(input logic [15:0] v, input logic s, input logic m,
                                 input logic [2:0] kr, input logic [2:0] ke, input logic [2:0] lq,
                                 input logic [31:0] ec, input logic [5:0] el, input logic et,
                                 output int waited);
        logic acc;
        exp_t e;
        val         = v;
        is_signed   = s;
        is_minus    = m;
        k_rice      = kr;
        k_exp       = ke;
        last_rice_q = lq;
        in_valid    = 1'b1;
        waited      = 0;
        acc         = 1'b0;
        while (!acc && waited < 50) begin
            #2;
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                e.code = ec;
                e.len  = el;
                e.tl   = et;
                exp_q.push_back(e);
            end else begin
                waited++;
            end
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for 50 cycles expected acceptance");
        end
    endtask

    // Drop in_valid and scramble the codebook inputs, which must be ignored.
    task automatic setIdle();
        in_valid    = 1'b0;
        val         = 16'hDEAD;
        is_signed   = 1'b1;
        is_minus    = 1'b1;
        k_rice      = 3'd5;
        k_exp       = 3'd6;
        last_rice_q = 3'd1;
    endtask

    // Called right after an accept with an empty pipeline and out_ready=1.
    task automatic checkLatency(input string tag);
        @(negedge clk);
        checkOutput({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_lat2"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_lat3"}, 64'(out_valid), 64'd1);
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (toggle_en) out_ready = ~out_ready;
        end
    end

    // Monitor: scoreboard pops plus stall-hold check
    initial begin
        logic        prev_stalled;
        logic [31:0] prev_code;
        logic [5:0]  prev_len;
        logic        prev_tl;
        int          idx;
        exp_t        e;
        prev_stalled = 1'b0;
        prev_code    = '0;
        prev_len     = '0;
        prev_tl      = 1'b0;
        idx          = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stalled = 1'b0;
            end else begin
                if (prev_stalled) begin
                    checks++;
                    if (out_valid !== 1'b1 || code !== prev_code || len !== prev_len || too_long !== prev_tl) begin
                        errors++;
                        $display("[TB] FAIL stall_hold: got valid=%0b code=0x%0h len=%0d tl=%0b expected valid=1 code=0x%0h len=%0d tl=%0b",
                                 out_valid, code, len, too_long, prev_code, prev_len, prev_tl);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_codeword: got code=0x%0h len=%0d expected no output", code, len);
                    end else begin
                        e = exp_q.pop_front();
                        if (code !== e.code || len !== e.len || too_long !== e.tl) begin
                            errors++;
                            $display("[TB] FAIL codeword[%0d]: got code=0x%0h len=%0d too_long=%0b expected code=0x%0h len=%0d too_long=%0b",
                                     idx, code, len, too_long, e.code, e.len, e.tl);
                        end
                    end
                    idx++;
                end
                prev_stalled = out_valid && !out_ready;
                prev_code    = code;
                prev_len     = len;
                prev_tl      = too_long;
            end
        end
    end

    initial begin
        int w;
        reset_n   = 1'b0;
        out_ready = 1'b1;
        setIdle();

        #3;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_code", 64'(code), 64'd0);
        checkOutput("rst_len", 64'(len), 64'd0);
        checkOutput("rst_too_long", 64'(too_long), 64'd0);
        #19;
        reset_n = 1'b1;

        // Rice: q=2, code=3, len=4; accepted on the first edge after release
        applyStimulus(16'd5, 1'b0, 1'b0, 3'd1, 3'd2, 3'd2, 32'd3, 6'd4, 1'b0, w);
        checkOutput("first_accept_wait", 64'(w), 64'd0);
        setIdle();
        checkLatency("rice5");
        waitDrain("rice5");

        // Exp mode: v2 = 9-6+4 = 7, e=2, len=6
        applyStimulus(16'd9, 1'b0, 1'b0, 3'd1, 3'd2, 3'd2, 32'd7, 6'd6, 1'b0, w);
        // Signed Rice k=0: code 1 -> 3, len 4 -> 5
        applyStimulus(16'd3, 1'b1, 1'b1, 3'd0, 3'd0, 3'd3, 32'd3, 6'd5, 1'b0, w);
        // Signed but zero magnitude: no sign bit
        applyStimulus(16'd0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd3, 32'd1, 6'd1, 1'b0, w);
        // v2 = 65528, e=15, len=39 > 32
        applyStimulus(16'hFFFF, 1'b0, 1'b0, 3'd0, 3'd0, 3'd7, 32'd65528, 6'd39, 1'b1, w);
        // len exactly MAX_LEN: v2 = 0x8000, e=15, len=32
        applyStimulus(16'h8000, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 32'h8000, 6'd32, 1'b0, w);
        // same with sign bit: len=33 crosses the limit
        applyStimulus(16'h8000, 1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 32'h10001, 6'd33, 1'b1, w);
        setIdle();
        waitDrain("directed");

        // Back-to-back with out_ready toggling every cycle
        toggle_en = 1'b1;
        applyStimulus(16'd0,   1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 32'd1,   6'd1,  1'b0, w);
        applyStimulus(16'd1,   1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 32'd1,   6'd2,  1'b0, w);
        applyStimulus(16'd6,   1'b1, 1'b0, 3'd2, 3'd1, 3'd3, 32'd12,  6'd5,  1'b0, w);
        applyStimulus(16'd7,   1'b1, 1'b1, 3'd2, 3'd1, 3'd3, 32'd15,  6'd5,  1'b0, w);
        applyStimulus(16'd20,  1'b0, 1'b0, 3'd1, 3'd3, 3'd1, 32'd24,  6'd8,  1'b0, w);
        applyStimulus(16'd100, 1'b1, 1'b1, 3'd3, 3'd0, 3'd2, 32'd155, 6'd17, 1'b0, w);
        applyStimulus(16'd15,  1'b0, 1'b0, 3'd3, 3'd2, 3'd1, 32'd15,  6'd5,  1'b0, w);
        applyStimulus(16'd255, 1'b1, 1'b0, 3'd7, 3'd7, 3'd7, 32'd510, 6'd10, 1'b0, w);
        setIdle();
        waitDrain("b2b");
        toggle_en = 1'b0;
        out_ready = 1'b1;

        // Fill pipeline while stalled, then reset with three symbols in flight
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(16'd5, 1'b0, 1'b0, 3'd1, 3'd2, 3'd2, 32'd3, 6'd4, 1'b0, w);
        applyStimulus(16'd9, 1'b0, 1'b0, 3'd1, 3'd2, 3'd2, 32'd7, 6'd6, 1'b0, w);
        applyStimulus(16'd3, 1'b1, 1'b1, 3'd0, 3'd0, 3'd3, 32'd3, 6'd5, 1'b0, w);
        setIdle();
        #3;
        checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
        checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_len", 64'(len), 64'd0);
        #14;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no_stale", 64'(out_valid), 64'd0);
        end
        applyStimulus(16'd20, 1'b0, 1'b0, 3'd1, 3'd3, 3'd1, 32'd24, 6'd8, 1'b0, w);
        setIdle();
        checkLatency("post_rst");
        waitDrain("post_rst");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
